// File: rtl/pc_seq_pkg.sv
// Shared types and default constants for the program-counter sequencer.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } seq_state_t;

    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0100;
    localparam int          DEFAULT_INSTR_BYTES  = 4;

    // Holds a redirect or trap that could not be applied in the cycle it arrived.
    typedef struct packed {
        logic        valid;
        logic        is_trap;
        logic [31:0] target;
    } redirect_buf_t;

endpackage

// File: rtl/pc_sequencer.sv
// Selects the next PC value and write enable for the program counter register.
// Define PC_SEQUENCER_MISALIGN_TRAP_EN to turn misaligned redirects into traps.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
    parameter logic [31:0] TRAP_VECTOR  = DEFAULT_TRAP_VECTOR,
    parameter int          INSTR_BYTES  = DEFAULT_INSTR_BYTES   // 2 or 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        trap_valid,
    input  logic        halt_req,
    input  logic        resume,
    output logic [31:0] next_pc,
    output logic        pc_write,
    output logic        fetch_valid,
    output logic        redirect_pending,
    output logic [31:0] stall_count
`ifdef PC_SEQUENCER_MISALIGN_TRAP_EN
    ,
    output logic        misalign_err
`endif
);

    localparam logic [31:0] LOW_MASK = 32'(INSTR_BYTES - 1);
    localparam logic [31:0] STEP     = 32'(INSTR_BYTES);

    seq_state_t    state_q, state_d;
    redirect_buf_t buf_q, buf_d;
    logic [31:0]   stall_count_q;
    logic          fetch_valid_q;
    logic          count_en;
    logic [31:0]   apply_target;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d      = state_q;
        buf_d        = buf_q;
        next_pc      = pc;
        pc_write     = 1'b0;
        count_en     = 1'b0;
        apply_target = '0;
`ifdef PC_SEQUENCER_MISALIGN_TRAP_EN
        misalign_err = 1'b0;
`endif

        unique case (state_q)
            BOOT: begin
                next_pc  = RESET_VECTOR;
                pc_write = 1'b1;
                state_d  = RUN;
            end

            RUN: begin
                // A trap buffered while halted behaves like a live trap request.
                if (trap_valid || (buf_q.valid && buf_q.is_trap)) begin
                    next_pc  = TRAP_VECTOR;
                    pc_write = 1'b1;
                    buf_d    = '0;
                end else if (stall) begin
                    count_en = 1'b1;
                    if (redirect_valid) begin
                        buf_d = '{valid: 1'b1, is_trap: 1'b0, target: redirect_target};
                    end
                end else if (redirect_valid || buf_q.valid) begin
                    apply_target = redirect_valid ? redirect_target : buf_q.target;
                    next_pc      = apply_target & ~LOW_MASK;
                    pc_write     = 1'b1;
                    buf_d        = '0;
`ifdef PC_SEQUENCER_MISALIGN_TRAP_EN
                    if ((apply_target & LOW_MASK) != '0) begin
                        next_pc      = TRAP_VECTOR;
                        misalign_err = 1'b1;
                    end
`endif
                end else begin
                    next_pc  = pc + STEP;
                    pc_write = 1'b1;
                end

                if (halt_req && !stall) begin
                    state_d = HALTED;
                end
            end

            HALTED: begin
                if (trap_valid) begin
                    buf_d.valid   = 1'b1;
                    buf_d.is_trap = 1'b1;
                end
                if (redirect_valid) begin
                    buf_d.valid  = 1'b1;
                    buf_d.target = redirect_target;
                end
                if (resume) begin
                    state_d = RUN;
                end
            end

            default: state_d = BOOT;
        endcase

        if (reset) begin
            next_pc  = RESET_VECTOR;
            pc_write = 1'b0;
`ifdef PC_SEQUENCER_MISALIGN_TRAP_EN
            misalign_err = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state_q       <= BOOT;
            buf_q         <= '0;
            stall_count_q <= '0;
            fetch_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            buf_q         <= buf_d;
            fetch_valid_q <= (state_d == RUN);
            if (count_en && (stall_count_q != 32'hFFFF_FFFF)) begin
                stall_count_q <= stall_count_q + 32'd1;
            end
        end
    end

    assign fetch_valid      = fetch_valid_q;
    assign redirect_pending = buf_q.valid;
    assign stall_count      = stall_count_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed plus randomized bench for pc_sequencer against a behavioural model,
// including a model of the program counter register it drives.
module tb_pc_sequencer;

    localparam logic [31:0] RV = 32'h0000_0000;
    localparam logic [31:0] TV = 32'h0000_0100;
    localparam int          IB = 4;
`ifdef PC_SEQUENCER_MISALIGN_TRAP_EN
    localparam bit MISALIGN_EN = 1'b1;
`else
    localparam bit MISALIGN_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_reg;
    logic        stall, redirect_valid, trap_valid, halt_req, resume;
    logic [31:0] redirect_target;
    logic [31:0] next_pc, stall_count;
    logic        pc_write, fetch_valid, redirect_pending;
    logic        err_obs;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    bit          m_boot, m_halted, m_fetch;
    bit          m_pend_valid, m_pend_trap;
    logic [31:0] m_pend_target;
    logic [31:0] m_stall_count;

`ifdef PC_SEQUENCER_MISALIGN_TRAP_EN
    logic misalign_err;
    assign err_obs = misalign_err;
`else
    assign err_obs = 1'b0;
`endif

    pc_sequencer dut (
        .clk              (clk),
        .reset            (reset),
        .pc               (pc_reg),
        .stall            (stall),
        .redirect_valid   (redirect_valid),
        .redirect_target  (redirect_target),
        .trap_valid       (trap_valid),
        .halt_req         (halt_req),
        .resume           (resume),
        .next_pc          (next_pc),
        .pc_write         (pc_write),
        .fetch_valid      (fetch_valid),
        .redirect_pending (redirect_pending),
        .stall_count      (stall_count)
`ifdef PC_SEQUENCER_MISALIGN_TRAP_EN
        ,
        .misalign_err     (misalign_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        reset = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
        trap_valid = 1'b0; halt_req = 1'b0; resume = 1'b0;
    endtask

    // Expected combinational outputs for the current inputs and model state.
    function automatic void model_outputs(output bit w, output logic [31:0] n, output bit e);
        logic [31:0] t;
        w = 1'b0; n = pc_reg; e = 1'b0;
        if (reset) begin
            n = RV;
        end else if (m_boot) begin
            w = 1'b1; n = RV;
        end else if (!m_halted) begin
            if (trap_valid || (m_pend_valid && m_pend_trap)) begin
                w = 1'b1; n = TV;
            end else if (stall) begin
                w = 1'b0;
            end else if (redirect_valid || m_pend_valid) begin
                t = redirect_valid ? redirect_target : m_pend_target;
                w = 1'b1;
                if (MISALIGN_EN && (t % IB) != 0) begin
                    n = TV; e = 1'b1;
                end else begin
                    n = t - (t % IB);
                end
            end else begin
                w = 1'b1;
                n = 32'((longint'(pc_reg) + IB) % 64'h1_0000_0000);
            end
        end
    endfunction

    function automatic void model_update(input bit w, input logic [31:0] n);
        if (w) pc_reg = n;
        if (reset) begin
            m_boot = 1'b1; m_halted = 1'b0; m_fetch = 1'b0;
            m_pend_valid = 1'b0; m_pend_trap = 1'b0; m_stall_count = '0;
        end else if (m_boot) begin
            m_boot = 1'b0; m_fetch = 1'b1;
        end else if (m_halted) begin
            if (trap_valid) begin m_pend_valid = 1'b1; m_pend_trap = 1'b1; end
            if (redirect_valid) begin m_pend_valid = 1'b1; m_pend_target = redirect_target; end
            if (resume) begin m_halted = 1'b0; m_fetch = 1'b1; end
        end else begin
            if (trap_valid || (m_pend_valid && m_pend_trap)) begin
                m_pend_valid = 1'b0; m_pend_trap = 1'b0;
            end else if (stall) begin
                if (m_stall_count != 32'hFFFF_FFFF) m_stall_count = m_stall_count + 1;
                if (redirect_valid) begin m_pend_valid = 1'b1; m_pend_target = redirect_target; end
            end else begin
                m_pend_valid = 1'b0;
            end
            if (halt_req && !stall) begin m_halted = 1'b1; m_fetch = 1'b0; end
        end
    endfunction

    // One clock: check at the falling edge, advance the model just after the rising edge.
    task automatic step(input string tag);
        bit          w, e;
        logic [31:0] n;
        @(negedge clk);
        model_outputs(w, n, e);
        check({tag, ".pc_write"}, {31'd0, pc_write}, {31'd0, w});
        if (w || reset) check({tag, ".next_pc"}, next_pc, n);
        check({tag, ".fetch_valid"}, {31'd0, fetch_valid}, {31'd0, m_fetch});
        check({tag, ".redirect_pending"}, {31'd0, redirect_pending}, {31'd0, m_pend_valid});
        check({tag, ".stall_count"}, stall_count, m_stall_count);
        if (MISALIGN_EN) check({tag, ".misalign_err"}, {31'd0, err_obs}, {31'd0, e});
        @(posedge clk);
        #1;
        model_update(w, n);
    endtask

    initial begin
        pc_reg = 32'h0;
        m_pend_target = '0;
        idle();
        reset = 1'b1;
        repeat (3) step("reset");

        // Boot sequence
        idle();
        step("boot");
        check("boot.pc_loaded", pc_reg, 32'h0);
        step("first_run");
        check("first_run.pc", pc_reg, 32'h4);

        // Redirect takes effect in one clock
        pc_reg = 32'h40;
        redirect_valid = 1'b1; redirect_target = 32'h200;
        step("redirect");
        idle();
        step("after_redirect");
        check("after_redirect.pc", pc_reg, 32'h204);

        // Three stalled cycles with a redirect buffered in the second
        stall = 1'b1;
        step("stall1");
        redirect_valid = 1'b1; redirect_target = 32'h300;
        step("stall2");
        redirect_valid = 1'b0;
        step("stall3");
        check("stall.count", stall_count, 32'd3);
        check("stall.pending", {31'd0, redirect_pending}, 32'd1);
        idle();
        step("unstall");
        check("unstall.pc", pc_reg, 32'h300);

        // Trap beats stall and redirect
        stall = 1'b1; trap_valid = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h700;
        step("trap_stall");
        idle();
        check("trap_stall.pc", pc_reg, TV);
        step("trap_after");

        // Wrap-around increment
        pc_reg = 32'hFFFF_FFFC;
        step("wrap");
        check("wrap.pc", pc_reg, 32'h0);

        // Halt, redirect while halted, resume
        halt_req = 1'b1;
        step("halt_enter");
        redirect_valid = 1'b1; redirect_target = 32'h500;
        step("halted1");
        redirect_valid = 1'b0;
        step("halted2");
        halt_req = 1'b0; resume = 1'b1;
        step("resume");
        idle();
        step("resume_apply");
        check("resume.pc", pc_reg, 32'h500);

        // Trap while halted takes precedence over a buffered redirect
        halt_req = 1'b1;
        step("halt2_enter");
        trap_valid = 1'b1;
        step("halted_trap");
        trap_valid = 1'b0; redirect_valid = 1'b1; redirect_target = 32'h640;
        step("halted_redir");
        idle(); resume = 1'b1;
        step("resume2");
        idle();
        step("resume2_apply");
        check("resume2.pc", pc_reg, TV);

        // Misaligned redirect
        redirect_valid = 1'b1; redirect_target = 32'h202;
        step("misalign");
        idle();
        check("misalign.pc", pc_reg, MISALIGN_EN ? TV : 32'h200);

        // Reset mid-operation discards a buffered redirect
        stall = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h900;
        step("pre_reset");
        idle(); reset = 1'b1;
        step("mid_reset");
        idle();
        step("reboot");
        check("reboot.pending", {31'd0, redirect_pending}, 32'd0);

        // Randomized traffic
        for (int i = 0; i < 500; i++) begin
            reset           = ($urandom_range(0, 99) < 1);
            stall           = ($urandom_range(0, 99) < 30);
            redirect_valid  = ($urandom_range(0, 99) < 25);
            redirect_target = $urandom;
            if ($urandom_range(0, 3) != 0) redirect_target = redirect_target & 32'hFFFF_FFFC;
            trap_valid      = ($urandom_range(0, 99) < 5);
            halt_req        = ($urandom_range(0, 99) < 5);
            resume          = ($urandom_range(0, 99) < 30);
            step("random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Controller that drives the program counter register's write enable and next-value inputs each cycle.
- Arbitrates between the boot vector, sequential increment, branch/jump redirect and trap entry.
- Honours pipeline stalls and debug halt.
- Sits between the fetch/decode control logic and the program counter register; reads back the current PC.

Parameters:
- RESET_VECTOR, 32'h0000_0000: PC loaded on the first cycle after reset.
- TRAP_VECTOR, 32'h0000_0100: PC loaded on trap entry.
- INSTR_BYTES, 4: sequential increment; legal values are 2 or 4.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- pc  in  32  current PC, from the program counter register output.
- stall  in  1  hold the PC this cycle.
- redirect_valid  in  1  branch/jump taken this cycle.
- redirect_target  in  32  target address, qualified by redirect_valid.
- trap_valid  in  1  trap request; highest priority after reset.
- halt_req  in  1  debug halt request (level).
- resume  in  1  debug resume pulse.
- next_pc  out  32  value presented to the PC register.
- pc_write  out  1  PC register write enable.
- fetch_valid  out  1  PC register holds a fetchable address.
- redirect_pending  out  1  a redirect is buffered awaiting application.
- stall_count  out  32  count of cycles in which the PC was held by stall.

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high.
- While reset is high:
  - state <= BOOT; pending buffer cleared; stall_count <= 0; fetch_valid <= 0.
  - Outputs: pc_write=0, next_pc=RESET_VECTOR.
  - Reset asserted mid-operation discards any pending redirect or trap.
- States (2-bit, registered): BOOT, RUN, HALTED.
- BOOT: pc_write=1, next_pc=RESET_VECTOR for exactly one cycle, then -> RUN. fetch_valid rises the following cycle.
- RUN: next_pc/pc_write are combinational from state, buffer and inputs. Priority:
  1. trap_valid: next_pc=TRAP_VECTOR, pc_write=1, clear the pending buffer. Applies even when stall=1.
  2. stall=1:
     - pc_write=0; stall_count += 1, saturating at 32'hFFFF_FFFF.
     - If redirect_valid, latch the target into the buffer. A newer redirect overwrites an older buffered one.
  3. Buffer valid: next_pc=buffered target, pc_write=1, clear the buffer. A simultaneous new redirect_valid replaces the buffer and is applied directly instead.
  4. redirect_valid: next_pc=redirect_target, pc_write=1.
  5. Otherwise: next_pc = pc + INSTR_BYTES, wrapping modulo 2^32 (32'hFFFF_FFFC + 4 = 0), pc_write=1.
- RUN -> HALTED when halt_req=1 and stall=0. The write selected that cycle still occurs.
- HALTED:
  - pc_write=0; fetch_valid <= 0.
  - redirect_valid is latched into the buffer.
  - trap_valid is latched as trap-pending; it takes precedence over the buffer on exit.
  - On resume=1 (halt_req ignored that cycle): -> RUN, fetch_valid <= 1. The buffered trap/redirect is applied on the first RUN cycle.
- Latency: redirect_valid to PC register updated = 1 clock when not stalled.
- Alignment: redirect_target bits below log2(INSTR_BYTES) are cleared before use, unless overridden by MISALIGN_TRAP_EN (see Optional Feature).
- redirect_pending = buffer valid flag (registered).

Optional Feature:
- Macro: PC_SEQUENCER_MISALIGN_TRAP_EN.
- Defined:
  - A redirect whose target has nonzero low bits is converted to a trap: next_pc=TRAP_VECTOR.
  - Adds output misalign_err (1 bit), pulsed high for one cycle coincident with the trap write; reset value 0.
  - Also applies to a misaligned target taken from the buffer.
- Undefined: low bits are silently cleared; the misalign_err port does not exist.

Decomposition:
- Package pc_seq_pkg holds:
  - the state enum type;
  - default RESET_VECTOR/TRAP_VECTOR constants;
  - the INSTR_BYTES default;
  - a redirect-buffer struct {valid, is_trap, target[31:0]}.
- No sub-module. The buffer, saturating counter and FSM stay inline. The program counter register is instantiated by the parent, not here.

Test Plan:
- Reset then release -> cycle 1: pc_write=1, next_pc=0x0; cycle 2: next_pc=0x4; fetch_valid=1.
- pc=0x40, redirect_valid=1, target=0x200, stall=0 -> next_pc=0x200 same cycle; following cycle next_pc=0x204.
- Hold stall=1 for 3 cycles; redirect to 0x300 in stall cycle 2; trap not asserted:
  - pc_write=0 for those 3 cycles; stall_count=3; redirect_pending=1;
  - first unstalled cycle: next_pc=0x300, redirect_pending cleared.
- trap_valid and redirect_valid together, stall=1 -> next_pc=TRAP_VECTOR (0x100), pc_write=1, buffer empty.
- pc=32'hFFFF_FFFC, no events -> next_pc=0x0000_0000.
- halt_req in RUN -> pc_write=0, fetch_valid=0; redirect 0x500 while halted; resume -> first RUN cycle next_pc=0x500.
- With PC_SEQUENCER_MISALIGN_TRAP_EN: redirect to 0x202 -> next_pc=0x100, misalign_err=1 for one cycle.
- Without PC_SEQUENCER_MISALIGN_TRAP_EN: redirect to 0x202 -> next_pc=0x200.
